// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer.
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int unsigned RST_CYCLES_DEF = 32'd2;

endpackage

// File: rtl/run_seq_edge.sv
// Rising-edge detector on a sampled level; resets high so a level held
// through reset release is not seen as an edge.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;

  // Previous-sample register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/run_seq.sv
// Run sequencer: holds the core in reset, lets it run until halt, counts run cycles.
// Optional watchdog enabled by defining RUN_SEQ_WATCHDOG_EN.
module run_seq
  import run_seq_pkg::*;
#(
  parameter int unsigned       RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned       CNT_W      = 32'd16,
  parameter logic [CNT_W-1:0]  WDOG_LIMIT = CNT_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             core_halt,
  output logic             core_reset,
  output logic             core_run,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [3:0]       HOLD_LAST_C = 4'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             core_reset_q, core_reset_d;
  logic             core_run_q, core_run_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             rise_s;
  logic             wdog_hit_s;

  edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (rise_s)
  );

`ifdef RUN_SEQ_WATCHDOG_EN
  // Trip on the edge that would make the count reach the limit.
  localparam logic [CNT_W-1:0] WDOG_PRE_C = WDOG_LIMIT - CNT_W'(1'b1);
  assign wdog_hit_s = (count_q == WDOG_PRE_C);
`else
  logic unused_wdog_s;
  assign unused_wdog_s = ^WDOG_LIMIT;
  assign wdog_hit_s    = 1'b0;
`endif

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    count_d      = count_q;
    core_reset_d = core_reset_q;
    core_run_d   = core_run_q;
    busy_d       = busy_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE, FINISH: begin
        if (rise_s) begin
          state_d      = HOLD;
          hold_d       = 4'd0;
          count_d      = {CNT_W{1'b0}};
          core_reset_d = 1'b1;
          core_run_d   = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          timeout_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST_C) begin
          state_d      = RUN;
          core_reset_d = 1'b0;
          core_run_d   = 1'b1;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      RUN: begin
        if (count_q == CNT_MAX_C) begin
          count_d = count_q;
        end else begin
          count_d = count_q + CNT_W'(1'b1);
        end
        // Halt has priority over a coincident watchdog trip.
        if (core_halt) begin
          state_d      = FINISH;
          core_reset_d = 1'b1;
          core_run_d   = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          timeout_d    = 1'b0;
        end else if (wdog_hit_s) begin
          state_d      = FINISH;
          core_reset_d = 1'b1;
          core_run_d   = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d      = IDLE;
        hold_d       = 4'd0;
        count_d      = {CNT_W{1'b0}};
        core_reset_d = 1'b1;
        core_run_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_q       <= 4'd0;
      count_q      <= {CNT_W{1'b0}};
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      core_reset_q <= core_reset_d;
      core_run_q   <= core_run_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign core_run    = core_run_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = count_q;

endmodule
